// File: rtl/mux_nto1_stream.sv
// -----------------------------------------------------------------------------
// mux_nto1_stream
//   Parametrised N:1 registered stream multiplexer with valid/ready handshake.
//   Two channel-select modes:
//     mode = 0 : static select, the channel indexed by sel is granted when valid
//     mode = 1 : round-robin, the first valid channel at or after rr_ptr wins
//   The output beat (valid/data/channel) is fully registered; one beat per
//   cycle, one cycle of latency from input handshake to output.
//
// Parameters
//   N      number of input channels (N >= 2)
//   WIDTH  data width per channel  (WIDTH >= 1)
//   SELW   channel-index width, derived from N (not overridable)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = static select via sel, 1 = round-robin
//   sel        channel index used in static mode (values >= N never grant)
//   in_valid   per-channel valid
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready, combinational, at most one bit set
//   out_valid  registered output valid
//   out_data   registered output data
//   out_chan   source channel of the current out_data
//   out_ready  consumer ready
// -----------------------------------------------------------------------------
module mux_nto1_stream #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  // Output register and round-robin pointer
  logic               vld_p0;
  logic [WIDTH-1:0]   data_p0;
  logic [SELW-1:0]    chan_p0;
  logic [SELW-1:0]    rr_ptr;

  // Combinational grant decision
  logic               load_en;
  logic               grant_vld;
  logic [SELW-1:0]    grant_idx;
  logic [WIDTH-1:0]   grant_data;
  logic               xfer;
  logic [SELW-1:0]    rr_next;

  // Channel index reached k steps after ptr, wrapping modulo N. N need not be
  // a power of two, so the wrap is explicit rather than relying on overflow.
  function automatic logic [SELW-1:0] rr_cand(input logic [SELW-1:0] ptr,
                                              input int              k);
    int c;
    c = int'(ptr) + k;
    if (c >= N) c = c - N;
    return SELW'(c);
  endfunction

  // Pointer value after serving channel g: the channel just after it.
  function automatic logic [SELW-1:0] rr_after(input logic [SELW-1:0] g);
    logic [SELW-1:0] nxt;
    if (g == SELW'(N - 1)) nxt = '0;
    else                   nxt = g + SELW'(1);
    return nxt;
  endfunction

  // The register can take a new beat when it is empty or being drained now.
  assign load_en = !vld_p0 || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      // Comparing sel against every legal index means an out-of-range sel
      // (possible when N is not a power of two) simply matches nothing.
      for (int i = 0; i < N; i++) begin
        if ((sel == SELW'(i)) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      // Scan from the farthest offset back to rr_ptr so the closest valid
      // channel to the pointer is the one left standing.
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[rr_cand(rr_ptr, k)]) begin
          grant_vld = 1'b1;
          grant_idx = rr_cand(rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // No handshake is offered while reset is held, even though the empty
  // register would otherwise make load_en true.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && load_en && grant_vld && (grant_idx == SELW'(i))) in_ready[i] = 1'b1;
    end
  end

  assign xfer    = load_en && grant_vld;
  assign rr_next = rr_after(grant_idx);

  // ---- stage p0: registered output beat ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      rr_ptr  <= '0;
    end else begin
      if (load_en) begin
        // A pop with nothing granted empties the register; data/chan hold.
        vld_p0 <= grant_vld;
        if (grant_vld) begin
          data_p0 <= grant_data;
          chan_p0 <= grant_idx;
        end
      end
      if (xfer && mode) rr_ptr <= rr_next;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_chan  = chan_p0;

  // A stalled beat must stay put until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p0 && !out_ready) |=> (vld_p0 && $stable(data_p0) && $stable(chan_p0)));

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

endmodule
